div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-cycle radix-2 divider serving DIV/DIVU in the execute stage, downstream of the main decoder. It consumes the decoder's `mdToHilo`, `mulOrdiv` and `mdIsSign` controls, which EX qualifies into `start` and `is_sign`. It stalls the pipeline through `busy` while it runs, then delivers the quotient and remainder to the HI/LO write path with a one-cycle `done` pulse. It supports cancellation by exception flush.

## Interface
- `WIDTH`, 32: operand and result width. Fixed at 32 for MIPS; a parameter only to allow a reduced-width bench.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: division request (level). EX drives it as `mdToHilo & (mulOrdiv==DIV)` and holds it until `done`.
- `is_sign` in 1: 1 = DIV (signed), 0 = DIVU. Sampled with `start` in IDLE.
- `a` in WIDTH: dividend (rs value). Sampled with `start` in IDLE.
- `b` in WIDTH: divisor (rt value). Sampled with `start` in IDLE.
- `cancel` in 1: flush from the exception/CP0 path. Aborts any operation in progress.
- `busy` out 1: stall request to the hazard unit.
- `done` out 1: one-cycle pulse; `hi` and `lo` are valid in this cycle.
- `hi` out WIDTH: remainder.
- `lo` out WIDTH: quotient.

## Operation
- States: IDLE, BUSY, DONE. Counter `cnt` is 5 bits.
- **IDLE**
  - If `start & ~cancel`, on the next edge: capture `|a|` and `|b|`. Capture sign flags `sa=is_sign&a[31]` and `sb=is_sign&b[31]`. Magnitude is the two's-complement negate when the flag is set, otherwise the raw value. Clear the partial remainder and set `cnt=0`. Go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - One restoring step per edge: `rem' = {rem[30:0], dvd[31]}`, `dvd` shifts left.
  - If `rem' >= |b|`: `rem = rem' - |b|` and the quotient bit is 1. Otherwise `rem = rem'` and the quotient bit is 0.
  - Intermediate subtraction is 33 bits wide.
  - `cnt` increments. The step taken at `cnt==31` is the last one; go to DONE.
  - On that same edge, register the sign-corrected result:
    - `lo` = quotient, negated if `sa^sb`.
    - `hi` = remainder, negated if `sa`.
- **DONE**
  - `done=1` for exactly one cycle, then go to IDLE unconditionally.
  - `start` seen in the cycle after DONE (in IDLE) is a new operation. EX must have advanced by then.
- **cancel** in BUSY or DONE: go to IDLE on the next edge, with no `done` and `hi`/`lo` unchanged. In the DONE cycle, `done` still reads 1 combinationally; the EX flush logic ignores it.
- `cancel` together with `start` in IDLE: the request is ignored.
- `hi`/`lo` hold the last completed result until the next completion.
- **Divide by zero**: no special case, no exception. The natural result of the iterations is:
  - Unsigned: `lo=0xFFFFFFFF`, `hi=a`.
  - Signed: that result with the sign correction above applied.
- **Overflow** `0x80000000 / 0xFFFFFFFF` signed: `lo=0x80000000`, `hi=0`. No trap.
- Operands are sampled only at IDLE→BUSY. Changes on `a`, `b` or `is_sign` during BUSY have no effect.

## Timing
- Reset (async, immediate): state=IDLE, `cnt=0`, `busy=0`, `done=0`, `hi=0`, `lo=0`, internal registers 0.
- `busy = (state==BUSY) | (state==IDLE & start & ~cancel)`. It is combinational, so EX stalls in the same cycle `start` rises.
- `done = (state==DONE)`. It is registered-state decode; no combinational path from inputs.
- Latency, with cycle 0 = `start` high in IDLE:
  - `busy` is high in cycles 0–32 (33 cycles).
  - `done` is high in cycle 33, with `hi`/`lo` valid.
  - `busy` is 0 in cycle 33, so the pipeline advances on the cycle-33 edge.
- Back-to-back: the earliest next `start` acceptance is cycle 34.
- Reset asserted mid-BUSY: immediate return to IDLE with all outputs 0. The operation is lost.

## Test plan
- **Unsigned:** DIVU `a=100`, `b=7`, `start` held → `busy` high cycles 0–32; `done` high cycle 33 only; `lo=14`, `hi=2`.
- **Signed, mixed signs:** DIV `a=0xFFFFFFF9` (-7), `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. Same operands as DIVU → `lo=0x7FFFFFFC`, `hi=1`.
- **Signed overflow and divide by zero:**
  - DIV `0x80000000 / 0xFFFFFFFF` → `lo=0x80000000`, `hi=0`.
  - DIVU `a=0x1234`, `b=0` → `lo=0xFFFFFFFF`, `hi=0x1234`.
- **Cancel:** start `1000/10`, assert `cancel` in cycle 15 → IDLE at cycle 16, no `done` pulse, `hi`/`lo` keep their prior values. A new DIVU `9/3` then gives `lo=3`, `hi=0` at cycle 33 of its own sequence.
- **Async reset:** assert `rst` mid-BUSY between clock edges → `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a new request completes normally.
- **Back-to-back with operand wiggle:** two consecutive DIVU ops with `a`/`b` toggling randomly during BUSY → results match the operands captured at acceptance. The second `busy` starts at cycle 34.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the iterative divider.
//
// Handshake: EX raises `start` (with `is_sign`, `a`, `b`) and holds it until it
// sees `done`. `busy` is high from the cycle `start` is first seen in IDLE until
// the cycle before `done`. `done` is a one-cycle pulse during which `hi`/`lo`
// carry the new result. `cancel` aborts any operation in progress and suppresses
// acceptance of a request in the same cycle.
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, is_sign, a, b, cancel,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, is_sign, a, b, cancel,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Works on magnitudes and
// sign-corrects the quotient/remainder on the final step, so the result is
// registered and ready in the single DONE cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   dbus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, quotient bits shift in at the LSB
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dsr;      // divisor magnitude
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last_step;

  // Request acceptance, operand magnitudes and one restoring step.
  // The shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1)
  // compare correctly; a borrow out of the subtract means "does not fit".
  always_comb begin
    accept    = (state == S_IDLE) & dbus.start & ~dbus.cancel & ~rst;
    a_neg     = dbus.is_sign & dbus.a[WIDTH-1];
    b_neg     = dbus.is_sign & dbus.b[WIDTH-1];
    a_mag     = a_neg ? ({WIDTH{1'b0}} - dbus.a) : dbus.a;
    b_mag     = b_neg ? ({WIDTH{1'b0}} - dbus.b) : dbus.b;
    rem_sh    = {rem, dvd[WIDTH-1]};
    diff      = rem_sh - {1'b0, dsr};
    q_bit     = ~diff[WIDTH];
    rem_nx    = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx    = {dvd[WIDTH-2:0], q_bit};
    last_step = (cnt == 5'(WIDTH - 1));
  end

  // Output decode: busy covers the accepting IDLE cycle so EX stalls at once.
  always_comb begin
    dbus.busy      = (state == S_BUSY) | accept;
    dbus.done      = (state == S_DONE);
    dbus.hi        = hi_q;
    dbus.lo        = lo_q;
    dbus.dbg_state = state;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dvd   <= a_mag;
            dsr   <= b_mag;
            sa    <= a_neg;
            sb    <= b_neg;
            rem   <= '0;
            cnt   <= 5'd0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dbus.cancel) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nx;
            dvd <= quo_nx;
            cnt <= cnt + 5'd1;
            if (last_step) begin
              lo_q  <= (sa ^ sb) ? ({WIDTH{1'b0}} - quo_nx) : quo_nx;
              hi_q  <= sa ? ({WIDTH{1'b0}} - rem_nx) : rem_nx;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of hand-computed quotients and
// remainders plus sequences for cancel, async reset and back-to-back requests.
module tb_div_unit;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) dbus();

  div_unit #(.WIDTH(32)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .dbus (dbus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_bad = 0;

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: one division, with cycle 0 = first cycle start is high in IDLE.
  // keep=1 leaves start high after done so the next call is back-to-back.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sign, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input bit keep, input bit wiggle);
    int busy_err;
    int done_err;
    int last;
    logic [31:0] lo_s;
    logic [31:0] hi_s;
    busy_err = 0;
    done_err = 0;
    lo_s = '0;
    hi_s = '0;
    @(negedge clk);
    dbus.a       = a;
    dbus.b       = b;
    dbus.is_sign = sign;
    dbus.cancel  = 1'b0;
    dbus.start   = 1'b1;
    #1;
    if (dbus.busy !== 1'b1) busy_err++;
    if (dbus.done !== 1'b0) done_err++;
    last = keep ? 33 : 34;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (dbus.busy !== ((c <= 32) ? 1'b1 : 1'b0)) busy_err++;
      if (dbus.done !== ((c == 33) ? 1'b1 : 1'b0)) done_err++;
      if (c == 33) begin
        lo_s = dbus.lo;
        hi_s = dbus.hi;
        if (!keep) dbus.start = 1'b0;
      end
      if (wiggle && c <= 32) begin
        dbus.a       = $urandom;
        dbus.b       = $urandom;
        dbus.is_sign = 1'($urandom_range(0, 1));
      end
    end
    check({tag, " busy_cycles_0_32"}, 32'(busy_err), 32'd0);
    check({tag, " done_cycle_33"}, 32'(done_err), 32'd0);
    check({tag, " lo"}, lo_s, exp_lo);
    check({tag, " hi"}, hi_s, exp_hi);
  endtask

  initial begin
    int done_seen;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
    vecs[4]  = '{32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234};
    vecs[5]  = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'd1,          32'hFFFFFFFB};
    vecs[6]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
    vecs[7]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF};
    vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0};
    vecs[9]  = '{32'hFFFFFFFF,   32'h80000001,   1'b0, 32'd1,          32'h7FFFFFFE};
    vecs[10] = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0};
    vecs[11] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};

    dbus.start   = 1'b0;
    dbus.is_sign = 1'b0;
    dbus.a       = '0;
    dbus.b       = '0;
    dbus.cancel  = 1'b0;
    rst          = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset busy", 32'(dbus.busy), 32'd0);
    check("reset done", 32'(dbus.done), 32'd0);
    check("reset hi", dbus.hi, 32'd0);
    check("reset lo", dbus.lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sign,
             vecs[i].lo, vecs[i].hi, 1'b0, 1'b0);
    end

    // cancel in cycle 15: back to IDLE, no done, result registers untouched
    @(negedge clk);
    dbus.a = 32'd1000; dbus.b = 32'd10; dbus.is_sign = 1'b0; dbus.start = 1'b1;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    check("cancel busy_c15", 32'(dbus.busy), 32'd1);
    dbus.cancel = 1'b1;
    @(negedge clk);
    check("cancel idle_c16", 32'(dbus.dbg_state), 32'd0);
    check("cancel busy_c16", 32'(dbus.busy), 32'd0);
    dbus.start = 1'b0;
    dbus.cancel = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dbus.done === 1'b1) done_seen++;
    end
    check("cancel no_done", 32'(done_seen), 32'd0);
    check("cancel lo_held", dbus.lo, vecs[NVEC-1].lo);
    check("cancel hi_held", dbus.hi, vecs[NVEC-1].hi);

    // start together with cancel in IDLE is ignored
    @(negedge clk);
    dbus.a = 32'd5; dbus.b = 32'd1; dbus.start = 1'b1; dbus.cancel = 1'b1;
    #1;
    check("start_cancel busy", 32'(dbus.busy), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dbus.busy === 1'b1 || dbus.done === 1'b1) done_seen++;
    end
    dbus.start = 1'b0; dbus.cancel = 1'b0;
    check("start_cancel idle", 32'(done_seen), 32'd0);

    run_op("after_cancel 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

    // async reset between edges in the middle of BUSY
    @(negedge clk);
    dbus.a = 32'd50; dbus.b = 32'd5; dbus.is_sign = 1'b0; dbus.start = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", 32'(dbus.busy), 32'd0);
    check("async_rst done", 32'(dbus.done), 32'd0);
    check("async_rst hi", dbus.hi, 32'd0);
    check("async_rst lo", dbus.lo, 32'd0);
    dbus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst 50/5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0);

    // back-to-back with operands toggling during BUSY
    run_op("b2b_first", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b1, 1'b1);
    run_op("b2b_second", 32'hDEADBEEF, 32'h00001234, 1'b0, 32'h000C3BA5, 32'h0000076B, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
